// File: rtl/multicycle_shifter.sv
// Iterative SLL/SRL/SRA/ROR unit that moves at most STEP bits per cycle.
// Operands and results use valid/ready handshakes.
module multicycle_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP = 4,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SHW-1:0]   in_shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // One extra bit so STEP == WIDTH and the full-width rotate count fit.
    localparam logic [SHW:0] STEPW = (SHW+1)'(STEP);
    localparam logic [SHW:0] WFULL = (SHW+1)'(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   rem;
    logic [SHW-1:0]   s;
    logic [SHW:0]     rot_amt;
    logic [WIDTH-1:0] stepped;
    logic             step_full;
    logic             accept;

    assign accept = in_valid && in_ready;

    always_comb begin
        step_full = {1'b0, rem} > STEPW;
        s         = step_full ? STEPW[SHW-1:0] : rem;
        rot_amt   = WFULL - {1'b0, s};
    end

    always_comb begin
        stepped = data;
        unique case (op)
            OP_SLL: stepped = data << s;
            OP_SRL: stepped = data >> s;
            OP_SRA: stepped = $signed(data) >>> s;
            OP_ROR: stepped = (data >> s) | (data << rot_amt);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op   <= OP_SLL;
            data <= '0;
            rem  <= '0;
        end else if (accept) begin
            op   <= in_op;
            data <= in_a;
            rem  <= in_shamt;
        end else if (state == BUSY) begin
            data <= stepped;
            rem  <= rem - s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A remainder within STEP finishes this cycle, including shamt 0.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (in_valid) state_nx = BUSY;
            end
            BUSY: begin
                if (!step_full) state_nx = DONE;
            end
            DONE: begin
                if (out_ready) state_nx = in_valid ? BUSY : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || (state == DONE && out_ready);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        out_res   = data;
    end

endmodule

// File: tb/tb_multicycle_shifter.sv
// Scoreboard bench for multicycle_shifter: random and directed shifts
// compared against an arithmetic reference model.
module tb_multicycle_shifter;

    localparam int WIDTH = 32;
    localparam int STEP = 4;
    localparam int SHW = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = 2'b00;
    logic [WIDTH-1:0] in_a = '0;
    logic [SHW-1:0]   in_shamt = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_res;
    logic             busy;

    typedef struct {
        logic [WIDTH-1:0] exp;
        int               acc;
        int               lat;
    } item_t;

    item_t sbq[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    mode = 0;
    bit    seen = 0;

    multicycle_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_op(in_op),
        .in_a(in_a),
        .in_shamt(in_shamt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_res(out_res),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: 0 always ready, 1 random, 2 stalled.
    always @(posedge clk) begin
        #2;
        case (mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    function automatic logic [WIDTH-1:0] ref_shift(
        input logic [1:0] op, input logic [WIDTH-1:0] a, input int sh);
        logic [2*WIDTH-1:0] t;
        case (op)
            2'b00: return a << sh;
            2'b01: return a >> sh;
            2'b10: return $signed(a) >>> sh;
            default: begin
                t = {a, a} >> sh;
                return t[WIDTH-1:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input int sh);
        return (sh == 0) ? 1 : (sh + STEP - 1) / STEP;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a,
                         input int sh, output int waited);
        item_t it;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_shamt = SHW'(sh);
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) break;
        end
        if (waited > 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0");
        end else begin
            it.exp = ref_shift(op, a, sh);
            it.acc = cyc + 1;
            it.lat = ref_lat(sh);
            sbq.push_back(it);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_shamt = SHW'($urandom);
        in_op    = 2'($urandom);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            seen = 0;
        end else if (out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stale_valid: out_valid=1 res=%h with nothing pending",
                         out_res);
            end else begin
                if (!seen) begin
                    chk("latency", cyc, sbq[0].acc + sbq[0].lat);
                    seen = 1;
                end
                if (out_ready) begin
                    chk("result", out_res, sbq[0].exp);
                    void'(sbq.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        int               w;
        int               n;
        logic [WIDTH-1:0] cap;
        logic [1:0]       dop[8] = '{2'b10, 2'b10, 2'b01, 2'b00,
                                     2'b00, 2'b10, 2'b11, 2'b11};
        logic [WIDTH-1:0] da[8]  = '{32'hfffffff8, 32'h8, 32'h80000000, 32'h8,
                                     32'h1, 32'h80000000, 32'h12345678,
                                     32'h12345678};
        int               dsh[8] = '{2, 2, 31, 0, 31, 31, 8, 4};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_res", out_res, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            issue(dop[i], da[i], dsh[i], w);
            repeat (9) @(posedge clk);
            #1;
        end

        // Backpressure, then back-to-back accept on the releasing edge.
        mode = 2;
        issue(2'b11, 32'h12345678, 8, w);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        chk("hold_reached", 32'(out_valid), 32'd1);
        cap = out_res;
        repeat (3) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_res", out_res, cap);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        mode = 0;
        issue(2'b01, 32'hdeadbeef, 13, w);
        chk("b2b_wait", w, 32'd0);
        repeat (6) @(posedge clk);
        #1;

        // Reset while a long SRL is in flight.
        issue(2'b01, 32'h80000000, 31, w);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_out_res", out_res, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        mode = 1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            issue(2'($urandom), $urandom, int'($urandom_range(0, 31)), w);
        end

        mode = 0;
        n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results never delivered", sbq.size());
        end
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_shifter.md
# multicycle_shifter

Parametrised, iterative shift unit for the RISC-V core's ALU path. It generalises the single-cycle `srai`/`srli`/`slli` datapath behaviour to any word width and adds a rotate-right mode. It spreads a shift of up to WIDTH-1 bits over several cycles, moving at most STEP bits per cycle. Operands enter and results leave through valid/ready handshakes, so the block can sit behind a multi-cycle or pipelined execute stage.

## Interface
Parameters:
- WIDTH, 32: data width in bits; power of two, ≥ 8.
- STEP, 4: maximum bits shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridden).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-low.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept a request.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_a  in  WIDTH  operand.
- in_shamt  in  SHW  shift amount, 0..WIDTH-1.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_res  out  WIDTH  result.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, BUSY, DONE.
- Accept: happens when `in_valid && in_ready`. At that edge the block latches op, a and rem=shamt, and goes to BUSY.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Each BUSY cycle:
  - s = min(rem, STEP); data = f(op, data, s); rem -= s.
  - When the new rem is 0, next state is DONE.
  - If rem is already 0 on entry (shamt=0), s=0, data is unchanged, and next state is DONE.
- Shift functions:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with the latched sign bit data[WIDTH-1]. The sign is invariant across steps, so the final result equals the signed a >>> shamt.
  - ROR: bits leaving the LSB re-enter at the MSB. The result is (a >> shamt) | (a << (WIDTH-shamt)); shamt=0 gives a.
- DONE: out_valid=1 and out_res holds the result.
  - DONE with out_ready=1 and in_valid=0: go to IDLE.
  - DONE with out_ready=1 and in_valid=1: accept the new request in the same edge and go to BUSY (back-to-back).
  - DONE with out_ready=0: stay in DONE; out_res and out_valid are held stable.
- in_op, in_a and in_shamt are sampled only on the accept edge. Changes at any other time are ignored.
- Reset (rst=0 at an edge), from any state including mid-BUSY: state to IDLE, rem=0, data=0. Any in-flight operation is discarded, and no out_valid follows it.

## Timing
- Reset values: in_ready=1, out_valid=0, out_res=0, busy=0.
- Latency from the accept edge to the first cycle with out_valid=1 is L = max(1, ceil(shamt/STEP)) cycles.
  - WIDTH=32, STEP=4 gives L ranging from 1 to 8.
- Throughput: one result per L+1 cycles with out_ready held at 1. A new request is accepted on the same edge the previous result is consumed.
- All outputs are registered or decoded from the state register only. There is no combinational path from in_* to out_*. in_ready depends combinationally on out_ready.

## Test plan
All scenarios use WIDTH=32, STEP=4, with out_ready=1 unless stated.
- SRA: a=0xfffffff8, shamt=2 -> out_res=0xfffffffe, out_valid 1 cycle after accept. Also a=0x00000008, shamt=2 -> 0x00000002.
- SRL and SLL extremes:
  - SRL a=0x80000000, shamt=31 -> 0x00000001, L=8.
  - SLL a=0x00000008, shamt=0 -> 0x00000008, L=1.
  - SLL a=0x1, shamt=31 -> 0x80000000.
  - SRA a=0x80000000, shamt=31 -> 0xffffffff.
- ROR: a=0x12345678, shamt=8 -> 0x78123456, L=2. Also shamt=4 -> 0x81234567, L=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_res stable, out_valid=1, in_ready=0 throughout. Raising out_ready together with in_valid accepts the next request on that edge with no idle cycle.
- Input stability: toggle in_a, in_shamt and in_op while BUSY -> result is unaffected and matches the values latched at accept.
- Reset mid-operation: pull rst low during BUSY of an SRL with shamt=31 -> next cycle in_ready=1, out_valid=0, busy=0, out_res=0, and no stale out_valid appears afterwards.
